// File: rtl/wb_mux_pkg.sv
// Shared definitions for the Wishbone slave mux.
// FSM state encoding and slave count.
package wb_mux_pkg;

  localparam int NSLV = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational region decoder for the Wishbone slave mux.
// The lowest-numbered matching region wins.
module wb_addr_decode #(
  parameter int ADDR_W = 24,
  parameter logic [ADDR_W-1:0] BASE0 = 24'h000000,
  parameter logic [ADDR_W-1:0] BASE1 = 24'h100000,
  parameter logic [ADDR_W-1:0] BASE2 = 24'h200000,
  parameter logic [ADDR_W-1:0] BASE3 = 24'h300000,
  parameter logic [ADDR_W-1:0] MASK0 = 24'hF00000,
  parameter logic [ADDR_W-1:0] MASK1 = 24'hF00000,
  parameter logic [ADDR_W-1:0] MASK2 = 24'hF00000,
  parameter logic [ADDR_W-1:0] MASK3 = 24'hF00000
) (
  input  logic [ADDR_W-1:0] adr,
  output logic              hit,
  output logic [1:0]        idx
);

  always_comb begin
    hit = 1'b1;
    idx = 2'd0;
    priority case (1'b1)
      ((adr & MASK0) == BASE0): idx = 2'd0;
      ((adr & MASK1) == BASE1): idx = 2'd1;
      ((adr & MASK2) == BASE2): idx = 2'd2;
      ((adr & MASK3) == BASE3): idx = 2'd3;
      default:                  hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_slave_mux.sv
// Single-master, 4-slave Wishbone classic interconnect.
// Registered request/response paths with timeout.
module wb_slave_mux
  import wb_mux_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2,
  parameter int TMO    = 255,
  parameter logic [ADDR_W-1:0] BASE0 = 24'h000000,
  parameter logic [ADDR_W-1:0] BASE1 = 24'h100000,
  parameter logic [ADDR_W-1:0] BASE2 = 24'h200000,
  parameter logic [ADDR_W-1:0] BASE3 = 24'h300000,
  parameter logic [ADDR_W-1:0] MASK0 = 24'hF00000,
  parameter logic [ADDR_W-1:0] MASK1 = 24'hF00000,
  parameter logic [ADDR_W-1:0] MASK2 = 24'hF00000,
  parameter logic [ADDR_W-1:0] MASK3 = 24'hF00000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   m_cyc,
  input  logic                   m_stb,
  input  logic                   m_we,
  input  logic [ADDR_W-1:0]      m_adr,
  input  logic [DATA_W-1:0]      m_dat_i,
  input  logic [SEL_W-1:0]       m_sel,
  output logic [DATA_W-1:0]      m_dat_o,
  output logic                   m_ack,
  output logic                   m_err,
  output logic [NSLV-1:0]        s_cyc,
  output logic [NSLV-1:0]        s_stb,
  output logic                   s_we,
  output logic [ADDR_W-1:0]      s_adr,
  output logic [DATA_W-1:0]      s_dat_o,
  output logic [SEL_W-1:0]       s_sel,
  input  logic [NSLV*DATA_W-1:0] s_dat_i,
  input  logic [NSLV-1:0]        s_ack,
  input  logic [NSLV-1:0]        s_err,
  output logic                   o_busy
);

  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_M1 = TW'(TMO - 1);
  localparam logic [TW-1:0] TMR_MAX = '1;

  state_e              state_q;
  logic [TW-1:0]       tmr_q;
  logic [1:0]          idx_q;
  logic                m_ack_q;
  logic                m_err_q;
  logic [DATA_W-1:0]   m_dat_q;
  logic [NSLV-1:0]     s_cyc_q;
  logic [NSLV-1:0]     s_stb_q;
  logic                s_we_q;
  logic [ADDR_W-1:0]   s_adr_q;
  logic [DATA_W-1:0]   s_dat_q;
  logic [SEL_W-1:0]    s_sel_q;

  logic                hit;
  logic [1:0]          idx;
  logic [NSLV-1:0]     idx_oh;

  wb_addr_decode #(
    .ADDR_W (ADDR_W),
    .BASE0  (BASE0),
    .BASE1  (BASE1),
    .BASE2  (BASE2),
    .BASE3  (BASE3),
    .MASK0  (MASK0),
    .MASK1  (MASK1),
    .MASK2  (MASK2),
    .MASK3  (MASK3)
  ) u_dec (
    .adr (m_adr),
    .hit (hit),
    .idx (idx)
  );

  assign idx_oh = NSLV'(1) << idx;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
      m_dat_q <= '0;
      s_cyc_q <= '0;
      s_stb_q <= '0;
      s_we_q  <= 1'b0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      s_sel_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          m_ack_q <= 1'b0;
          m_err_q <= 1'b0;
          if (m_cyc && m_stb) begin
            s_we_q  <= m_we;
            s_adr_q <= m_adr;
            s_dat_q <= m_dat_i;
            s_sel_q <= m_sel;
            tmr_q   <= '0;
            if (hit) begin
              idx_q   <= idx;
              s_cyc_q <= idx_oh;
              s_stb_q <= idx_oh;
              state_q <= ACTIVE;
            end else begin
              m_err_q <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        ACTIVE: begin
          // Abort beats any response; err beats ack.
          if (!m_cyc) begin
            s_cyc_q <= '0;
            s_stb_q <= '0;
            state_q <= IDLE;
          end else if (s_err[idx_q]) begin
            s_cyc_q <= '0;
            s_stb_q <= '0;
            m_err_q <= 1'b1;
            state_q <= RESP;
          end else if (s_ack[idx_q]) begin
            s_cyc_q <= '0;
            s_stb_q <= '0;
            m_ack_q <= 1'b1;
            if (!s_we_q)
              m_dat_q <= s_dat_i[idx_q*DATA_W +: DATA_W];
            state_q <= RESP;
          end else if (tmr_q == TMO_M1) begin
            s_cyc_q <= '0;
            s_stb_q <= '0;
            m_err_q <= 1'b1;
            state_q <= RESP;
          end else if (tmr_q != TMR_MAX) begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        RESP: begin
          m_ack_q <= 1'b0;
          m_err_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_dat_o = m_dat_q;
  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;
  assign s_cyc   = s_cyc_q;
  assign s_stb   = s_stb_q;
  assign s_we    = s_we_q;
  assign s_adr   = s_adr_q;
  assign s_dat_o = s_dat_q;
  assign s_sel   = s_sel_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_wb_slave_mux.sv
// Bench for wb_slave_mux: directed cases plus random
// transactions against a per-transaction outcome model.
module tb_wb_slave_mux;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_cyc, m_stb, m_we;
  logic [23:0] m_adr;
  logic [15:0] m_dat_i;
  logic [1:0]  m_sel;
  logic [15:0] m_dat_o;
  logic        m_ack, m_err;
  logic [3:0]  s_cyc, s_stb;
  logic        s_we;
  logic [23:0] s_adr;
  logic [15:0] s_dat_o;
  logic [1:0]  s_sel;
  logic [63:0] s_dat_i;
  logic [3:0]  s_ack, s_err;
  logic        o_busy;

  int tests = 0;
  int fails = 0;
  logic [15:0] mdl_dat;

  always #5 clk = ~clk;

  wb_slave_mux #(.TMO(TMO)) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat_i (m_dat_i),
    .m_sel   (m_sel),
    .m_dat_o (m_dat_o),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_adr   (s_adr),
    .s_dat_o (s_dat_o),
    .s_sel   (s_sel),
    .s_dat_i (s_dat_i),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .o_busy  (o_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ack"},  m_ack,   0);
    chk({tag, "_err"},  m_err,   0);
    chk({tag, "_cyc"},  s_cyc,   0);
    chk({tag, "_stb"},  s_stb,   0);
    chk({tag, "_we"},   s_we,    0);
    chk({tag, "_adr"},  s_adr,   0);
    chk({tag, "_sdat"}, s_dat_o, 0);
    chk({tag, "_sel"},  s_sel,   0);
    chk({tag, "_mdat"}, m_dat_o, 0);
    chk({tag, "_busy"}, o_busy,  0);
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 silent, 4 master abort.
  // d: stb cycles seen before the slave answers (or aborts).
  task automatic run_txn(input string tag,
                         input logic [23:0] adr,
                         input logic we,
                         input logic [15:0] dat,
                         input logic [1:0] sel,
                         input int kind,
                         input int d,
                         input logic [15:0] rdat);
    bit hit;
    int k;
    logic [3:0] oh;
    int es, ea, ee;
    int stbc, nack, nerr, acyc, ecyc, ohbad, cycbad;
    logic [23:0] c_adr;
    logic c_we;
    logic [15:0] c_dat;
    logic [1:0] c_sel;
    logic [31:0] r0, r1;
    hit = (adr[23:20] < 4'd4);
    k = int'(adr[21:20]);
    oh = 4'b0001 << k;
    es = 0; ea = 0; ee = 0;
    if (!hit) ee = 1;
    else begin
      case (kind)
        0: begin es = d + 1; ea = d + 2; end
        1, 2: begin es = d + 1; ee = d + 2; end
        3: begin es = TMO; ee = TMO + 1; end
        default: es = d;
      endcase
      if (kind == 0 && !we) mdl_dat = rdat;
    end
    stbc = 0; nack = 0; nerr = 0;
    acyc = 0; ecyc = 0; ohbad = 0; cycbad = 0;
    c_adr = '0; c_we = 1'b0; c_dat = '0; c_sel = '0;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we;
    m_adr = adr; m_dat_i = dat; m_sel = sel;
    s_ack = '0; s_err = '0;
    for (int c = 1; c <= TMO + 4; c++) begin
      @(negedge clk);
      if (s_stb != 4'b0) begin
        stbc++;
        if (s_stb !== oh) ohbad++;
        if (stbc == 1) begin
          c_adr = s_adr; c_we = s_we;
          c_dat = s_dat_o; c_sel = s_sel;
        end
      end
      if (s_cyc !== s_stb) cycbad++;
      if (m_ack) begin nack++; acyc = c; end
      if (m_err) begin nerr++; ecyc = c; end
      if (m_ack || m_err) begin m_cyc = 1'b0; m_stb = 1'b0; end
      if (kind == 4 && hit && s_stb != 4'b0 && stbc == d) begin
        m_cyc = 1'b0; m_stb = 1'b0;
      end
      r0 = $urandom; r1 = $urandom;
      s_dat_i = {r1, r0};
      s_dat_i[k*16 +: 16] = rdat;
      r0 = $urandom;
      s_ack = r0[3:0];
      s_err = r0[7:4];
      if (hit) begin
        s_ack = s_ack & ~oh;
        s_err = s_err & ~oh;
      end
      if (hit && kind < 3 && s_stb[k] && stbc == d + 1) begin
        s_ack[k] = (kind != 1);
        s_err[k] = (kind != 0);
      end
      if (hit && kind == 3 && m_err) s_ack[k] = 1'b1;
    end
    s_ack = '0; s_err = '0;
    chk({tag, "_stbcnt"}, stbc, es);
    chk({tag, "_nack"}, nack, (ea != 0) ? 1 : 0);
    chk({tag, "_nerr"}, nerr, (ee != 0) ? 1 : 0);
    chk({tag, "_ackcyc"}, acyc, ea);
    chk({tag, "_errcyc"}, ecyc, ee);
    chk({tag, "_onehot"}, ohbad, 0);
    chk({tag, "_cyc"}, cycbad, 0);
    chk({tag, "_mdat"}, m_dat_o, mdl_dat);
    chk({tag, "_busy"}, o_busy, 0);
    if (es > 0) begin
      chk({tag, "_sadr"}, c_adr, adr);
      chk({tag, "_swe"}, c_we, we);
      chk({tag, "_sdat"}, c_dat, dat);
      chk({tag, "_ssel"}, c_sel, sel);
    end
  endtask

  initial begin
    int kind, d, n;
    logic [31:0] ra, rd;
    logic [23:0] adr;
    m_cyc = 0; m_stb = 0; m_we = 0;
    m_adr = '0; m_dat_i = '0; m_sel = '0;
    s_dat_i = '0; s_ack = '0; s_err = '0;
    mdl_dat = '0;
    rst_n = 1'b0;
    #1;
    chk_idle_outs("rst0");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Put a read into data so the mid-ACTIVE reset must clear it.
    run_txn("pre", 24'h1000AA, 1'b0, 16'h0, 2'b11, 0, 0, 16'h5A5A);

    @(negedge clk);
    m_cyc = 1; m_stb = 1; m_we = 1;
    m_adr = 24'h100000; m_dat_i = 16'hCAFE; m_sel = 2'b10;
    n = 0;
    while (s_stb !== 4'b0010 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_stb", s_stb, 4'b0010);
    chk("rst_mid_busy", o_busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle_outs("rst_mid");
    mdl_dat = '0;
    m_cyc = 0; m_stb = 0; m_we = 0;
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("rd_s1", 24'h100004, 1'b0, 16'h0, 2'b11, 0, 2, 16'hBEEF);
    run_txn("wr_s3", 24'h300010, 1'b1, 16'h1234, 2'b01, 0, 1, 16'h7777);
    run_txn("unmap", 24'h500000, 1'b0, 16'h0, 2'b11, 0, 0, 16'h1111);
    run_txn("tmo_s0", 24'h000020, 1'b0, 16'h0, 2'b11, 3, 0, 16'h2222);
    run_txn("ackerr", 24'h200000, 1'b0, 16'h0, 2'b11, 2, 1, 16'h3333);
    run_txn("abort", 24'h200002, 1'b0, 16'h0, 2'b11, 4, 2, 16'h4444);
    run_txn("rd_s0z", 24'h0000FE, 1'b0, 16'h0, 2'b11, 0, 0, 16'h0F0F);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rd = $urandom;
      adr = {ra[23:20] & 4'h7, ra[19:0]};
      kind = $urandom_range(0, 4);
      d = (kind == 4) ? $urandom_range(1, 5)
                      : $urandom_range(0, 5);
      run_txn("rnd", adr, ra[31], rd[15:0], ra[25:24],
              kind, d, rd[31:16]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
